instr_encoder_loader: RTL

- Inverse of the instruction decoder: takes decoded instruction fields and packs them into 9-bit machine code.
- Writes each packed word sequentially into instruction memory through a single write port.
- Used by the boot/test loader to fill program memory before the core is released from reset.
- Field combinations the decoder cannot represent are rejected and flagged; nothing is written for them.

---
 rtl/instr_encoder_loader.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_loader
// Brief    : Packs decoded instruction fields into 9-bit machine code and
//            writes the words sequentially into instruction memory.
//            Optional macro ENC_READBACK_EN adds a read-back verify step.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    op,
    input  logic [2:0]    ra,
    input  logic [2:0]    rb,
    input  logic [2:0]    wd,
    input  logic [4:0]    imm,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [8:0]    mem_wdata,
    input  logic [8:0]    mem_rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          err,
    output logic [1:0]    err_code
);

    localparam logic [2:0]  c_st_idle  = 3'd0;
    localparam logic [2:0]  c_st_enc   = 3'd1;
    localparam logic [2:0]  c_st_wr    = 3'd2;
`ifdef ENC_READBACK_EN
    localparam logic [2:0]  c_st_rdreq = 3'd3;
    localparam logic [2:0]  c_st_rdchk = 3'd4;
`endif
    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);
    localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);

    logic [2:0]    r_state;
    logic [3:0]    r_op;
    logic [2:0]    r_ra, r_rb, r_wd;
    logic [4:0]    r_imm;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          r_err;
    logic [1:0]    r_err_code;
    logic          r_pend;
    logic [AW-1:0] r_pend_base;

    logic [8:0]    w_code;
    logic          w_illegal;
    logic [1:0]    w_alu_n;
    logic          w_done;

    // op 3/4/5 map to ALU function 0/1/2
    assign w_alu_n = r_op[1:0] + 2'd1;

    always_comb begin
        w_code    = '0;
        w_illegal = 1'b0;
        case (r_op)
            4'd0:  begin w_code = {4'b0000, r_wd, r_ra[1:0]}; w_illegal = r_ra[2]; end
            4'd1:  begin w_code = {4'b0001, r_ra[1:0], r_rb}; w_illegal = r_ra[2]; end
            4'd2:  begin w_code = {3'b001, r_ra, r_rb};       w_illegal = (r_wd != r_rb); end
            4'd3, 4'd4, 4'd5: begin
                w_code    = {3'b010, w_alu_n, r_ra[1:0], r_rb[1:0]};
                w_illegal = r_ra[2] | r_rb[2] | (r_wd != r_ra);
            end
            4'd6:  begin w_code = {5'b01011, 2'b00, r_ra[1:0]}; w_illegal = r_ra[2] | (r_wd != r_ra); end
            4'd7:  begin w_code = {5'b01011, 2'b10, r_ra[1:0]}; w_illegal = r_ra[2] | (r_wd != r_ra); end
            4'd8:  begin w_code = {5'b01011, 2'b01, r_ra[1:0]}; w_illegal = r_ra[2] | (r_wd != r_ra); end
            4'd9:  begin
                w_code    = {3'b011, r_ra, r_imm[2:0]};
                w_illegal = (r_wd != r_ra) | (|r_imm[4:3]);
            end
            4'd10: w_code = {4'b1001, r_imm};
            4'd11: w_code = {4'b1000, r_imm};
            4'd12: w_code = {3'b101, r_ra, r_rb};
            4'd13: w_code = {3'b110, r_ra, r_rb};
            default: begin
                w_code    = {3'b111, r_op[0], r_ra[1:0], r_imm[2:0]};
                w_illegal = r_ra[2] | (r_wd != r_ra) | (|r_imm[4:3]);
            end
        endcase
    end

    // Last cycle of an accepted descriptor: where a pending start is applied
    always_comb begin
        w_done = 1'b0;
        case (r_state)
            c_st_enc:   w_done = w_illegal;
`ifdef ENC_READBACK_EN
            c_st_rdchk: w_done = 1'b1;
`else
            c_st_wr:    w_done = 1'b1;
`endif
            default:    w_done = 1'b0;
        endcase
    end

`ifndef ENC_READBACK_EN
    logic w_unused_rdata;
    assign w_unused_rdata = ^mem_rdata;
`endif

    assign full      = (r_count == c_depth);
    assign in_ready  = Reset_n & (r_state == c_st_idle) & ~full & ~start;
    assign mem_we    = Reset_n & (r_state == c_st_wr);
    assign mem_addr  = Reset_n ? r_wr_ptr : '0;
    assign mem_wdata = mem_we ? w_code : '0;
    assign count     = r_count;
    assign err       = r_err;
    assign err_code  = r_err_code;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state     <= c_st_idle;
            r_op        <= '0;
            r_ra        <= '0;
            r_rb        <= '0;
            r_wd        <= '0;
            r_imm       <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_err_code  <= 2'd0;
            r_pend      <= 1'b0;
            r_pend_base <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid && in_ready) begin
                        r_op    <= op;
                        r_ra    <= ra;
                        r_rb    <= rb;
                        r_wd    <= wd;
                        r_imm   <= imm;
                        r_state <= c_st_enc;
                    end else if (in_valid && full && !start) begin
                        if (!r_err) r_err_code <= 2'd2;
                        r_err <= 1'b1;
                    end
                end
                c_st_enc: begin
                    if (w_illegal) begin
                        if (!r_err) r_err_code <= 2'd1;
                        r_err   <= 1'b1;
                        r_state <= c_st_idle;
                    end else begin
                        r_state <= c_st_wr;
                    end
                end
`ifdef ENC_READBACK_EN
                c_st_wr:    r_state <= c_st_rdreq;
                c_st_rdreq: r_state <= c_st_rdchk;
                c_st_rdchk: begin
                    if (mem_rdata != w_code) begin
                        if (!r_err) r_err_code <= 2'd3;
                        r_err <= 1'b1;
                    end
                    r_wr_ptr <= r_wr_ptr + c_ptr_one;
                    r_count  <= r_count + c_cnt_one;
                    r_state  <= c_st_idle;
                end
`else
                c_st_wr: begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_one;
                    r_count  <= r_count + c_cnt_one;
                    r_state  <= c_st_idle;
                end
`endif
                default: r_state <= c_st_idle;
            endcase

            // start overrides the pointer/count/error updates made above
            if (r_state == c_st_idle) begin
                if (start) begin
                    r_wr_ptr   <= base_addr;
                    r_count    <= '0;
                    r_err      <= 1'b0;
                    r_err_code <= 2'd0;
                end
            end else if (w_done) begin
                if (start || r_pend) begin
                    r_wr_ptr   <= start ? base_addr : r_pend_base;
                    r_count    <= '0;
                    r_err      <= 1'b0;
                    r_err_code <= 2'd0;
                end
                r_pend <= 1'b0;
            end else if (start) begin
                r_pend      <= 1'b1;
                r_pend_base <= base_addr;
            end
        end
    end

endmodule
`default_nettype wire
